// File: rtl/mix_signature_capture.sv
// mix_signature_capture
//   Capture stage for the 8-bit cluster-mix output. A start pulse launches a
//   run: SETTLE cycles are discarded, then WINDOW qualified bytes are folded
//   into an 8-bit MISR. The signature is held on a valid/ready handshake.
//
// Ports
//   clk        : clock, all state on posedge
//   rst        : synchronous active-high reset
//   start      : one-cycle run request, accepted only in IDLE
//   data_in    : byte to compact
//   sample_en  : qualifies data_in while capturing
//   sig_out    : MISR value, meaningful while sig_valid=1
//   sig_valid  : signature available (HOLD)
//   sig_ready  : consumer accepts the signature
//   busy       : run in progress (SETTLE, CAPTURE, HOLD)
//   overrun    : sticky, start seen outside IDLE
//   sig_count  : completed handshakes, wraps mod 256
module mix_signature_capture #(
  parameter int unsigned WINDOW = 16,
  parameter int unsigned SETTLE = 2,
  parameter logic [7:0]  POLY   = 8'h1D,
  parameter logic [7:0]  SEED   = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       sample_en,
  output logic [7:0] sig_out,
  output logic       sig_valid,
  input  logic       sig_ready,
  output logic       busy,
  output logic       overrun,
  output logic [7:0] sig_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_HOLD
  } state_t;

  localparam logic [7:0] SETTLE_LOAD = (SETTLE == 0) ? 8'd0 : 8'(SETTLE - 1);
  localparam logic [7:0] LAST_SAMPLE = 8'(WINDOW - 1);

  state_t     r_state;
  logic [7:0] r_misr;
  logic [7:0] r_settle_cnt;
  logic [7:0] r_sample_cnt;
  logic [7:0] r_sig_count;
  logic       r_overrun;

  state_t     w_state_nxt;
  logic [7:0] w_misr_nxt;
  logic [7:0] w_settle_nxt;
  logic [7:0] w_sample_nxt;
  logic [7:0] w_sig_count_nxt;
  logic       w_overrun_nxt;
  logic [7:0] w_misr_step;

  // Shift with polynomial feedback from the outgoing MSB, then fold the byte in.
  assign w_misr_step = ({r_misr[6:0], 1'b0} ^ (r_misr[7] ? POLY : 8'h00)) ^ data_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_misr       <= '0;
      r_settle_cnt <= '0;
      r_sample_cnt <= '0;
      r_sig_count  <= '0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_misr       <= w_misr_nxt;
      r_settle_cnt <= w_settle_nxt;
      r_sample_cnt <= w_sample_nxt;
      r_sig_count  <= w_sig_count_nxt;
      r_overrun    <= w_overrun_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_misr_nxt      = r_misr;
    w_settle_nxt    = r_settle_cnt;
    w_sample_nxt    = r_sample_cnt;
    w_sig_count_nxt = r_sig_count;
    // Any start outside IDLE, including the handshake cycle, is flagged.
    w_overrun_nxt   = r_overrun | (start & (r_state != ST_IDLE));

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_misr_nxt   = SEED;
          w_sample_nxt = '0;
          w_settle_nxt = SETTLE_LOAD;
          w_state_nxt  = (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (r_settle_cnt == 8'd0) begin
          w_state_nxt = ST_CAPTURE;
        end else begin
          w_settle_nxt = r_settle_cnt - 8'd1;
        end
      end
      ST_CAPTURE: begin
        if (sample_en) begin
          w_misr_nxt   = w_misr_step;
          w_sample_nxt = r_sample_cnt + 8'd1;
          if (r_sample_cnt == LAST_SAMPLE) begin
            w_state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (sig_ready) begin
          w_state_nxt     = ST_IDLE;
          w_sig_count_nxt = r_sig_count + 8'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign sig_out   = r_misr;
  assign sig_valid = (r_state == ST_HOLD);
  assign busy      = (r_state != ST_IDLE);
  assign overrun   = r_overrun;
  assign sig_count = r_sig_count;

endmodule

// File: tb/tb_mix_signature_capture.sv
// Bench for mix_signature_capture: four instances with different WINDOW/SETTLE
// share data/enable/ready and reset, each with its own start line.
//   0: WINDOW=1  SETTLE=0    1: WINDOW=2  SETTLE=0
//   2: WINDOW=1  SETTLE=2    3: WINDOW=16 SETTLE=2
module tb_mix_signature_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] start_v;
  logic [7:0] data_in;
  logic       sample_en;
  logic       sig_ready;
  logic [7:0] so [4];
  logic       sv [4];
  logic       bz [4];
  logic       ov [4];
  logic [7:0] sc [4];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mix_signature_capture #(.WINDOW(1), .SETTLE(0), .POLY(8'h1D), .SEED(8'hFF)) u_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .data_in(data_in), .sample_en(sample_en),
    .sig_out(so[0]), .sig_valid(sv[0]), .sig_ready(sig_ready), .busy(bz[0]),
    .overrun(ov[0]), .sig_count(sc[0]));
  mix_signature_capture #(.WINDOW(2), .SETTLE(0), .POLY(8'h1D), .SEED(8'hFF)) u_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .data_in(data_in), .sample_en(sample_en),
    .sig_out(so[1]), .sig_valid(sv[1]), .sig_ready(sig_ready), .busy(bz[1]),
    .overrun(ov[1]), .sig_count(sc[1]));
  mix_signature_capture #(.WINDOW(1), .SETTLE(2), .POLY(8'h1D), .SEED(8'hFF)) u_c (
    .clk(clk), .rst(rst), .start(start_v[2]), .data_in(data_in), .sample_en(sample_en),
    .sig_out(so[2]), .sig_valid(sv[2]), .sig_ready(sig_ready), .busy(bz[2]),
    .overrun(ov[2]), .sig_count(sc[2]));
  mix_signature_capture #(.WINDOW(16), .SETTLE(2), .POLY(8'h1D), .SEED(8'hFF)) u_d (
    .clk(clk), .rst(rst), .start(start_v[3]), .data_in(data_in), .sample_en(sample_en),
    .sig_out(so[3]), .sig_valid(sv[3]), .sig_ready(sig_ready), .busy(bz[3]),
    .overrun(ov[3]), .sig_count(sc[3]));

  typedef struct packed {
    logic [1:0]      inst;
    logic [3:0][7:0] d;      // d[i] drives the edge i+1 after the start edge
    logic [3:0]      en;
    logic [7:0]      sig;
    logic [2:0]      vedge;  // first edge (after start edge) where valid is seen
  } vec_t;

  vec_t tbl [7];
  int   exp_cnt [4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // GF(2) polynomial MISR step: multiply by x modulo x^8+x^4+x^3+x^2+1, add byte.
  function automatic logic [7:0] misr_ref(input logic [7:0] m, input logic [7:0] d);
    logic [8:0] t;
    t = {m, 1'b0};
    if (t[8]) t = t ^ 9'h11D;
    return t[7:0] ^ d;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
  endtask

  initial begin
    logic [7:0] m;
    int unsigned acc, c;
    logic hold, done, exp_ov, st, en_l, rdy_l;
    logic [7:0] d_l;
    logic [7:0] held;
    int unsigned inst;

    rst = 1'b1; start_v = '1; data_in = 8'h00; sample_en = 1'b0; sig_ready = 1'b0;

    // Reset with start asserted on every instance.
    step(); step();
    rst = 1'b0; start_v = '0;
    for (int i = 0; i < 4; i++) begin
      chk("rst_busy", 32'(bz[i]), 0);
      chk("rst_valid", 32'(sv[i]), 0);
      chk("rst_sig", 32'(so[i]), 0);
      chk("rst_count", 32'(sc[i]), 0);
      chk("rst_overrun", 32'(ov[i]), 0);
    end
    step();
    chk("rst_busy_after", 32'(bz[3]), 0);
    for (int i = 0; i < 4; i++) exp_cnt[i] = 0;

    // Directed runs.
    tbl[0] = '{inst: 2'd0, d: 32'h00000000, en: 4'b0001, sig: 8'hE3, vedge: 3'd1};
    tbl[1] = '{inst: 2'd0, d: 32'h0000005A, en: 4'b0001, sig: 8'hB9, vedge: 3'd1};
    tbl[2] = '{inst: 2'd0, d: 32'h12345600, en: 4'b1111, sig: 8'hE3, vedge: 3'd1};
    tbl[3] = '{inst: 2'd1, d: 32'h00000000, en: 4'b0011, sig: 8'hDB, vedge: 3'd2};
    tbl[4] = '{inst: 2'd1, d: 32'h0000AA00, en: 4'b0101, sig: 8'hDB, vedge: 3'd3};
    tbl[5] = '{inst: 2'd1, d: 32'h00003412, en: 4'b0011, sig: 8'hCB, vedge: 3'd2};
    tbl[6] = '{inst: 2'd2, d: 32'h00005555, en: 4'b0111, sig: 8'hE3, vedge: 3'd3};

    for (int k = 0; k < 7; k++) begin
      inst = 32'(tbl[k].inst);
      start_v[inst] = 1'b1;
      step();
      start_v = '0;
      chk("tbl_valid_t0", 32'(sv[inst]), 0);
      chk("tbl_busy_t0", 32'(bz[inst]), 1);
      for (int i = 0; i < 5; i++) begin
        if (i < 4) begin
          data_in = tbl[k].d[i];
          sample_en = tbl[k].en[i];
        end else begin
          data_in = 8'hC3;
          sample_en = 1'b1;
        end
        step();
        chk("tbl_valid", 32'(sv[inst]), 32'((i + 1) >= int'(tbl[k].vedge)));
        chk("tbl_busy", 32'(bz[inst]), 1);
        if ((i + 1) >= int'(tbl[k].vedge)) chk("tbl_sig", 32'(so[inst]), 32'(tbl[k].sig));
      end
      sample_en = 1'b0;
      sig_ready = 1'b1;
      step();
      sig_ready = 1'b0;
      exp_cnt[inst]++;
      chk("tbl_valid_drop", 32'(sv[inst]), 0);
      chk("tbl_busy_drop", 32'(bz[inst]), 0);
      chk("tbl_count", 32'(sc[inst]), 32'(exp_cnt[inst] & 255));
      chk("tbl_overrun", 32'(ov[inst]), 0);
    end

    // Randomized runs on the WINDOW=16 / SETTLE=2 instance.
    do_reset();
    exp_ov = 1'b0;
    for (int run = 0; run < 40; run++) begin
      start_v[3] = 1'b1;
      data_in = 8'($urandom);
      sample_en = 1'($urandom);
      sig_ready = 1'($urandom);
      step();
      chk("rnd_busy_t0", 32'(bz[3]), 1);
      chk("rnd_valid_t0", 32'(sv[3]), 0);
      m = 8'hFF; acc = 0; hold = 1'b0; done = 1'b0; c = 0;
      while (!done && c < 200) begin
        c++;
        d_l = 8'($urandom);
        en_l = ($urandom_range(0, 3) != 0);
        rdy_l = ($urandom_range(0, 2) == 0);
        st = (run >= 10) && ($urandom_range(0, 7) == 0);
        data_in = d_l; sample_en = en_l; sig_ready = rdy_l; start_v[3] = st;
        if (st) exp_ov = 1'b1;
        step();
        if (hold && rdy_l) begin
          done = 1'b1;
          exp_cnt[3]++;
        end else if (!hold && c > 2 && en_l) begin
          m = misr_ref(m, d_l);
          acc++;
          if (acc == 16) hold = 1'b1;
        end
        chk("rnd_busy", 32'(bz[3]), 32'(!done));
        chk("rnd_valid", 32'(sv[3]), 32'(hold && !done));
        if (hold && !done) chk("rnd_sig", 32'(so[3]), 32'(m));
        chk("rnd_overrun", 32'(ov[3]), 32'(exp_ov));
        chk("rnd_count", 32'(sc[3]), 32'(exp_cnt[3] & 255));
      end
      if (!done) chk("rnd_timeout", 0, 1);
    end
    start_v = '0; sample_en = 1'b0; sig_ready = 1'b0;

    // Backpressure with a start pulse during HOLD.
    do_reset();
    start_v[3] = 1'b1;
    step();
    start_v = '0;
    m = 8'hFF;
    for (int i = 1; i <= 18; i++) begin
      d_l = 8'($urandom);
      data_in = d_l; sample_en = 1'b1;
      step();
      if (i > 2) m = misr_ref(m, d_l);
      chk("bp_valid_rise", 32'(sv[3]), 32'(i == 18));
    end
    chk("bp_sig", 32'(so[3]), 32'(m));
    held = m;
    for (int i = 0; i < 5; i++) begin
      data_in = 8'($urandom);
      start_v[3] = (i == 2);
      step();
      chk("bp_hold_sig", 32'(so[3]), 32'(held));
      chk("bp_hold_valid", 32'(sv[3]), 1);
      chk("bp_hold_busy", 32'(bz[3]), 1);
    end
    start_v = '0;
    chk("bp_overrun", 32'(ov[3]), 1);
    chk("bp_count_before", 32'(sc[3]), 0);
    sig_ready = 1'b1;
    step();
    sig_ready = 1'b0;
    chk("bp_count_after", 32'(sc[3]), 1);
    chk("bp_valid_drop", 32'(sv[3]), 0);
    chk("bp_busy_drop", 32'(bz[3]), 0);

    // Reset while capturing: no signature may appear.
    start_v[3] = 1'b1;
    step();
    start_v = '0;
    sample_en = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("mid_busy_pre", 32'(bz[3]), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_busy", 32'(bz[3]), 0);
    chk("mid_valid", 32'(sv[3]), 0);
    chk("mid_sig", 32'(so[3]), 0);
    chk("mid_count", 32'(sc[3]), 0);
    chk("mid_overrun", 32'(ov[3]), 0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("mid_no_valid", 32'(sv[3]), 0);
    end

    // 256 back-to-back runs with ready held high: count wraps to zero.
    sig_ready = 1'b1; sample_en = 1'b1; data_in = 8'h00;
    for (int r = 0; r < 256; r++) begin
      start_v[0] = 1'b1;
      step();
      start_v = '0;
      step();
      chk("wrap_valid", 32'(sv[0]), 1);
      step();
      chk("wrap_count", 32'(sc[0]), 32'((r + 1) & 255));
    end
    chk("wrap_zero", 32'(sc[0]), 0);
    chk("wrap_overrun", 32'(ov[0]), 0);
    sig_ready = 1'b0; sample_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mix_signature_capture.md
# mix_signature_capture

Downstream capture stage for the top-level 8-bit cluster-mix output. On a start pulse it waits a settle interval, then compacts a window of output bytes into an 8-bit MISR signature and presents it on a valid/ready handshake. This lets the test harness check the whole core array with one byte per run instead of sampling every cycle.

## Interface
- `WINDOW`, 16: number of accepted samples per signature; legal range 1..255.
- `SETTLE`, 2: cycles discarded after start before capture begins; legal range 0..255.
- `POLY`, 8'h1D: MISR feedback polynomial taps (x^8+x^4+x^3+x^2+1).
- `SEED`, 8'hFF: MISR value loaded on start.

Ports:
- `clk`  in  1: single clock; all state on posedge.
- `rst`  in  1: synchronous reset, active-high.
- `start`  in  1: one-cycle request to begin a run; accepted only in IDLE.
- `data_in`  in  8: mixed cluster output byte.
- `sample_en`  in  1: qualifies `data_in` during CAPTURE.
- `sig_out`  out  8: signature; valid when `sig_valid`=1.
- `sig_valid`  out  1: signature available.
- `sig_ready`  in  1: consumer accepts signature.
- `busy`  out  1: high in SETTLE, CAPTURE and HOLD.
- `overrun`  out  1: sticky; set when `start` is seen outside IDLE.
- `sig_count`  out  8: number of completed handshakes; wraps 255->0.

## Operation
- States: IDLE, SETTLE, CAPTURE, HOLD.
- IDLE, `start`=1: load MISR=SEED and clear the sample counter. Go to SETTLE with the settle counter set to SETTLE-1. If SETTLE=0, go directly to CAPTURE.
- SETTLE: decrement the settle counter each cycle. On the cycle it reads 0, go to CAPTURE. `data_in` is ignored.
- CAPTURE, `sample_en`=1: MISR update is fb=misr[7]; misr <= ({misr[6:0],1'b0} ^ (fb ? POLY : 8'h00)) ^ data_in. Increment the sample counter.
  - When the accepted sample is the WINDOW-th, go to HOLD.
  - `sample_en`=0: MISR and the counter hold.
- HOLD: `sig_valid`=1 and `sig_out`=MISR, held stable.
  - On `sig_valid & sig_ready`: go to IDLE and increment `sig_count` (mod 256).
- `start` in any state other than IDLE: ignored and sets `overrun`. This includes the handshake cycle in HOLD. `overrun` is cleared only by `rst`.
- `sig_out` is driven by the MISR register in all states. Consumers use it only while `sig_valid`=1.
- All arithmetic is 8-bit, with XOR only in the MISR. The sample counter is 8 bits wide.

## Timing
- Reset takes priority over all inputs, including `start` in the same cycle. The cycle after `rst`=1: state=IDLE, `sig_out`=8'h00, `sig_valid`=0, `busy`=0, `overrun`=0, `sig_count`=0, internal counters=0.
- `start` sampled at edge T: `busy`=1 from T+1.
  - SETTLE occupies cycles T+1..T+SETTLE.
  - The first sample is absorbed at edge T+SETTLE+1.
- With `sample_en` held high, the WINDOW-th sample is absorbed at edge T+SETTLE+WINDOW. `sig_valid` rises in the same cycle.
- The handshake at edge H drops `sig_valid` and `busy` at H+1, and `sig_count` updates at H+1.
  - A new `start` can be accepted at H+1 at the earliest.
- `sig_ready` has no effect outside HOLD. `sig_ready` may be held high permanently, giving one HOLD cycle per run.
- `rst` mid-run: the run is aborted and all outputs return to reset values the next cycle. No partial signature is emitted.

## Test plan
- Reset check: drive `rst`=1 for 2 cycles with `start`=1 -> after release, `busy`=0, `sig_valid`=0, `sig_out`=00, `sig_count`=0, `overrun`=0.
- Single-sample run (WINDOW=1, SETTLE=0, SEED=FF, POLY=1D): pulse `start`, then `data_in`=00 with `sample_en`=1 -> `sig_valid` 2 cycles after `start`, `sig_out`=8'hE3.
- Two-sample run (WINDOW=2, SETTLE=0), data 00,00 -> `sig_out`=8'hDB.
  - Repeat with a `sample_en`=0 bubble between the two samples (data_in=AA during the bubble) -> same DB, with `sig_valid` one cycle later.
- Settle discard (WINDOW=1, SETTLE=2): `data_in`=55 during the two settle cycles, then 00 on the capture cycle -> `sig_out`=E3 and `sig_valid` at T+3.
- Backpressure plus overrun: hold `sig_ready`=0 for 5 cycles in HOLD and pulse `start` there.
  - Required: `sig_out` stable, `overrun`=1, state unchanged.
  - Then raise `sig_ready` -> `sig_count` 0->1 and state returns to IDLE.
- Count wrap and mid-run reset: complete 256 runs -> `sig_count` returns to 0. Assert `rst` during CAPTURE -> no `sig_valid` pulse and `busy`=0 the next cycle.
